sram_req_ctrl: RTL and testbench

Request/response front-end for the team's synchronous single-port SRAM. Accepts read/write requests on a valid/ready channel and drives the SRAM's en/rw/addr/in pins. Captures the SRAM's one-cycle-latency read data into a 2-entry response FIFO so the consumer can apply backpressure without losing data. Out-of-range addresses are trapped here and never reach the array.

---
 rtl/sram_req_ctrl.sv | 98 +++++++++
 tb/tb_sram_req_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for a single-port synchronous SRAM.
// Reads return through a 2-entry response FIFO; out-of-range accesses never reach the array.
module sram_req_ctrl #(
   parameter int SIZE       = 16,
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_rw,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  wr_err,
   output logic                  mem_en,
   output logic                  mem_rw,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

   logic [1:0]            occ;
   logic                  rd_pend;
   logic                  rd_pend_err;
   logic                  head;
   logic                  tail;
   logic [DATA_WIDTH-1:0] fifo_data [2];
   logic [1:0]            fifo_err;

   logic acc;
   logic inrange;
   logic push;
   logic pop;

   assign inrange   = ({1'b0, req_addr} < SIZE_W);
   assign rsp_valid = (occ != 2'd0);
   assign pop       = rsp_valid && rsp_ready;
   assign push      = rd_pend;

   // A slot is reserved at accept time, so an in-flight read counts against the FIFO;
   // a same-cycle pop frees one, which makes rsp_ready -> req_ready combinational.
   assign req_ready = ((occ + {1'b0, rd_pend}) < 2'd2) || pop;
   assign acc       = req_valid && req_ready && !rst;

   assign mem_en    = acc && inrange;
   assign mem_rw    = req_rw;
   assign mem_addr  = req_addr;
   assign mem_wdata = req_wdata;

   // Head is gated so idle and post-reset outputs read as zero without clearing storage.
   assign rsp_rdata = rsp_valid ? fifo_data[head] : '0;
   assign rsp_err   = rsp_valid && fifo_err[head];

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ         <= 2'd0;
         rd_pend     <= 1'b0;
         rd_pend_err <= 1'b0;
         wr_err      <= 1'b0;
         head        <= 1'b0;
         tail        <= 1'b0;
      end else begin
         rd_pend     <= acc && !req_rw;
         rd_pend_err <= acc && !req_rw && !inrange;
         if (acc && req_rw && !inrange) begin
            wr_err <= 1'b1;
         end
         if (push) begin
            tail <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // NOTE: FIFO storage has no reset; occ and the output gating make stale entries invisible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[tail] <= rd_pend_err ? '0 : mem_rdata;
         fifo_err[tail]  <= rd_pend_err;
      end
   end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl (SIZE = 12 so both in-range and trapped addresses occur).
// A transaction-level model predicts every output each cycle; directed phases pin it with literals.
module tb_sram_req_ctrl;

   localparam int SIZE = 12;
   localparam int DW   = 4;
   localparam int AW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid, req_ready, req_rw;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, wr_err;
   logic [DW-1:0] rsp_rdata;
   logic          mem_en, mem_rw;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   sram_req_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .wr_err(wr_err),
      .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Attached SRAM: one-cycle read latency, contents survive controller reset.
   logic          sram_clr;
   logic [DW-1:0] sram_arr [16];
   always @(posedge clk) begin
      if (sram_clr) begin
         for (int i = 0; i < 16; i++) sram_arr[i] <= '0;
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_rw) sram_arr[mem_addr] <= mem_wdata;
         else        mem_rdata <= sram_arr[mem_addr];
      end
   end

   // Reference model: outstanding reads as a queue of {visible-from cycle, err, data}.
   typedef struct {
      int          vis;
      logic        err;
      logic [DW-1:0] data;
   } rsp_t;

   rsp_t          q[$];
   logic [DW:0]   log_q[$];
   logic [DW-1:0] ref_mem [16];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            acc_count = 0;
   bit            checks_on = 1'b0;
   bit            exp_valid = 1'b0, exp_ready = 1'b0, exp_acc = 1'b0, exp_pop = 1'b0;
   bit            exp_wr_err = 1'b0;
   logic [DW:0]   seen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial for (int i = 0; i < 16; i++) ref_mem[i] = '0;

   // Compare process: predict this cycle's outputs from the model, then compare.
   always @(negedge clk) begin
      if (checks_on) begin
         exp_valid = (q.size() != 0) && (q[0].vis <= cyc);
         exp_ready = (q.size() < 2) || (exp_valid && rsp_ready);
         exp_acc   = req_valid && exp_ready && !rst;
         exp_pop   = exp_valid && rsp_ready;
         check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("mem_en", 32'(mem_en), 32'(exp_acc && (int'(req_addr) < SIZE)));
         check("mem_rw", 32'(mem_rw), 32'(req_rw));
         check("mem_addr", 32'(mem_addr), 32'(req_addr));
         check("mem_wdata", 32'(mem_wdata), 32'(req_wdata));
         check("wr_err", 32'(wr_err), 32'(exp_wr_err));
         if (exp_valid) begin
            check("rsp_rdata", 32'(rsp_rdata), 32'(q[0].data));
            check("rsp_err", 32'(rsp_err), 32'(q[0].err));
         end
         seen = {rsp_err, rsp_rdata};
      end
   end

   // Model update at the clock edge using the decisions predicted above.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         exp_wr_err = 1'b0;
         exp_acc    = 1'b0;
         exp_pop    = 1'b0;
         checks_on  = 1'b1;
      end else if (checks_on) begin
         if (exp_pop) begin
            log_q.push_back(seen);
            void'(q.pop_front());
         end
         if (exp_acc) begin
            acc_count++;
            if (req_rw) begin
               if (int'(req_addr) < SIZE) ref_mem[req_addr] = req_wdata;
               else                       exp_wr_err = 1'b1;
            end else if (int'(req_addr) < SIZE) begin
               q.push_back('{vis: cyc + 1, err: 1'b0, data: ref_mem[req_addr]});
            end else begin
               q.push_back('{vis: cyc + 1, err: 1'b1, data: '0});
            end
         end
      end
   end

   // Present one request and hold it until accepted; called #1 after a rising edge.
   task automatic send(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int   n;
      logic took;
      n = 0;
      took = 1'b0;
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = a;
      req_wdata = d;
      while (!took && n < 200) begin
         @(negedge clk);
         took = req_ready;
         n++;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!took) check("accept_timeout", 32'(took), 32'd1);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int   t_acc, n, c0, a0;
      logic saw;
      req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; sram_clr = 1'b1;
      step(3);
      rst = 1'b0; sram_clr = 1'b0;

      // Reset state
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_wr_err", 32'(wr_err), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // Write then read addr 3: two cycles from accept to response
      rsp_ready = 1'b1;
      send(1'b1, 4'd3, 4'hA);
      send(1'b0, 4'd3, 4'h0);
      t_acc = cyc - 1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 10);
      check("read_latency", 32'(cyc - t_acc), 32'd2);
      check("read3_data", 32'(rsp_rdata), 32'hA);
      check("read3_err", 32'(rsp_err), 32'd0);
      step(1);

      // Fill every address with its own value, then stream 16 reads
      for (int a = 0; a < 16; a++) send(1'b1, AW'(a), DW'(a));
      check("wr_err_sticky", 32'(wr_err), 32'd1);
      for (int a = 12; a < 16; a++) check("sram_untouched", 32'(sram_arr[a]), 32'd0);
      log_q.delete();
      c0 = cyc;
      for (int a = 0; a < 16; a++) send(1'b0, AW'(a), 4'h0);
      check("stream_no_stall", 32'(cyc - c0), 32'd16);
      step(4);
      check("stream_count", 32'(log_q.size()), 32'd16);
      for (int a = 0; a < 16; a++) begin
         if (log_q.size() > a)
            check("stream_rsp", 32'(log_q[a]), (a < SIZE) ? 32'(a) : 32'h10);
      end

      // Backpressure: only two reads get in while rsp_ready is low
      rsp_ready = 1'b0;
      log_q.delete();
      a0 = acc_count;
      fork
         begin
            send(1'b0, 4'd1, 4'h0);
            send(1'b0, 4'd2, 4'h0);
            send(1'b0, 4'd5, 4'h0);
            send(1'b0, 4'd9, 4'h0);
         end
      join_none
      repeat (6) @(posedge clk);
      #2;
      check("bp_accepted", 32'(acc_count - a0), 32'd2);
      check("bp_ready_low", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      wait fork;
      step(4);
      check("bp_count", 32'(log_q.size()), 32'd4);
      if (log_q.size() == 4) begin
         check("bp_rsp0", 32'(log_q[0]), 32'd1);
         check("bp_rsp1", 32'(log_q[1]), 32'd2);
         check("bp_rsp2", 32'(log_q[2]), 32'd5);
         check("bp_rsp3", 32'(log_q[3]), 32'd9);
      end

      // Write followed immediately by a read of the same address
      log_q.delete();
      send(1'b1, 4'd5, 4'h3);
      send(1'b0, 4'd5, 4'h0);
      step(3);
      check("raw_count", 32'(log_q.size()), 32'd1);
      if (log_q.size() == 1) check("raw_data", 32'(log_q[0]), 32'h3);

      // Push and pop on the same edge with one entry held
      rsp_ready = 1'b0;
      log_q.delete();
      send(1'b0, 4'd6, 4'h0);
      step(1);
      send(1'b0, 4'd7, 4'h0);
      rsp_ready = 1'b1;
      step(1);
      rsp_ready = 1'b0;
      check("pp_valid", 32'(rsp_valid), 32'd1);
      check("pp_head", 32'(rsp_rdata), 32'd7);
      check("pp_popped", 32'(log_q.size()), 32'd1);
      if (log_q.size() == 1) check("pp_first", 32'(log_q[0]), 32'd6);
      rsp_ready = 1'b1;
      step(2);
      check("pp_drained", 32'(log_q.size()), 32'd2);

      // Random traffic against the model
      repeat (400) begin
         req_valid = 1'($urandom_range(0, 1));
         req_rw    = 1'($urandom_range(0, 1));
         req_addr  = AW'($urandom_range(0, 15));
         req_wdata = DW'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      step(4);
      send(1'b1, 4'd13, 4'h1);
      check("pre_rst_wr_err", 32'(wr_err), 32'd1);

      // Reset with one entry held and one read in flight
      rsp_ready = 1'b0;
      send(1'b0, 4'd1, 4'h0);
      send(1'b0, 4'd2, 4'h0);
      rst = 1'b1;
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 4'd3;
      step(2);
      rst = 1'b0;
      req_valid = 1'b0;
      check("post_rst_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_wr_err", 32'(wr_err), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      rsp_ready = 1'b1;
      saw = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) saw = 1'b1;
      end
      check("no_stale_rsp", 32'(saw), 32'd0);
      step(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
